// File: rtl/player_pkg.sv
// Shared types and constants for the player sprite controller: FSM states,
// keycodes, playfield bounds, spawn point and sprite half-extents.
package player_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_HIT    = 2'd1,
        ST_INVULN = 2'd2,
        ST_DEAD   = 2'd3
    } state_t;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;

    localparam int HALF_W = 17;
    localparam int HALF_H = 16;

    localparam int SCREEN_X_MIN = 6;
    localparam int SCREEN_X_MAX = 633;
    localparam int SCREEN_Y_MIN = 6;
    localparam int SCREEN_Y_MAX = 473;

    // Limits apply to the sprite centre, so the whole sprite stays on screen.
    localparam int X_MIN = SCREEN_X_MIN + HALF_W;
    localparam int X_MAX = SCREEN_X_MAX - HALF_W;
    localparam int Y_MIN = SCREEN_Y_MIN + HALF_H;
    localparam int Y_MAX = SCREEN_Y_MAX - HALF_H;

    localparam logic [9:0] SPAWN_X = 10'd320;
    localparam logic [9:0] SPAWN_Y = 10'd450;

    function automatic logic [9:0] clamp_axis(input logic signed [10:0] v,
                                              input int lo, input int hi);
        logic signed [10:0] lo_s;
        logic signed [10:0] hi_s;
        logic signed [10:0] r;
        lo_s = 11'(lo);
        hi_s = 11'(hi);
        if (v < lo_s)
            r = lo_s;
        else if (v > hi_s)
            r = hi_s;
        else
            r = v;
        return r[9:0];
    endfunction

endpackage

// File: rtl/player_hit_detect.sv
// Combinational box-overlap test between the player sprite and one enemy.
module player_hit_detect
    import player_pkg::*;
(
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic [9:0] enemy_x,
    input  logic [9:0] enemy_y,
    input  logic [9:0] enemy_size,
    input  logic       enemy_alive,
    output logic       overlap
);

    logic [11:0] px;
    logic [11:0] py;
    logic [11:0] ex;
    logic [11:0] ey;
    logic [11:0] sz;

    assign px = {2'b00, pos_x};
    assign py = {2'b00, pos_y};
    assign ex = {2'b00, enemy_x};
    assign ey = {2'b00, enemy_y};
    assign sz = {2'b00, enemy_size};

    // The half-size is moved to the enemy side so nothing can underflow.
    assign overlap = enemy_alive
                  && (px <= ex + sz + 12'(HALF_W))
                  && (px + 12'(HALF_W) > ex)
                  && (py <= ey + sz + 12'(HALF_H))
                  && (py + 12'(HALF_H) > ey);

endmodule

// File: rtl/player_sprite_ctrl.sv
// Player movement, collision and lives FSM, one update per frame.
// Define PLAYER_INVULN_EN to enable the post-respawn invulnerability window.
module player_sprite_ctrl
    import player_pkg::*;
#(
    parameter int N_ENEMY       = 4,
    parameter int N_KEYS        = 3,
    parameter int STEP          = 3,
    parameter int LIVES         = 3,
    parameter int INVULN_FRAMES = 120
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic [8*N_KEYS-1:0]    keycode,
    input  logic [10*N_ENEMY-1:0]  enemy_x,
    input  logic [10*N_ENEMY-1:0]  enemy_y,
    input  logic [10*N_ENEMY-1:0]  enemy_size,
    input  logic [N_ENEMY-1:0]     enemy_alive,
    input  logic                   start,
    output logic [9:0]             pos_x,
    output logic [9:0]             pos_y,
    output logic [9:0]             half_w,
    output logic [9:0]             half_h,
    output logic [2:0]             lives,
    output logic [N_ENEMY-1:0]     hit_vec,
    output logic                   invuln,
    output logic                   game_over
);

    state_t               state_reg;
    logic [9:0]           pos_x_reg;
    logic [9:0]           pos_y_reg;
    logic [2:0]           lives_reg;
    logic [N_ENEMY-1:0]   hit_vec_reg;
    logic                 game_over_reg;
    logic [N_ENEMY-1:0]   overlap_vec;

    logic key_a, key_d, key_w, key_s;
    logic signed [10:0] step_s;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic [9:0] x_next;
    logic [9:0] y_next;

    always_comb begin
        key_a = 1'b0;
        key_d = 1'b0;
        key_w = 1'b0;
        key_s = 1'b0;
        for (int k = 0; k < N_KEYS; k++) begin
            if (keycode[8*k +: 8] == KEY_A) key_a = 1'b1;
            if (keycode[8*k +: 8] == KEY_D) key_d = 1'b1;
            if (keycode[8*k +: 8] == KEY_W) key_w = 1'b1;
            if (keycode[8*k +: 8] == KEY_S) key_s = 1'b1;
        end
    end

    // Opposing keys cancel; each axis is resolved independently for diagonals.
    assign step_s = 11'(STEP);

    always_comb begin
        dx = '0;
        dy = '0;
        if (key_d && !key_a) dx = step_s;
        if (key_a && !key_d) dx = -step_s;
        if (key_s && !key_w) dy = step_s;
        if (key_w && !key_s) dy = -step_s;
    end

    assign x_next = clamp_axis($signed({1'b0, pos_x_reg}) + dx, X_MIN, X_MAX);
    assign y_next = clamp_axis($signed({1'b0, pos_y_reg}) + dy, Y_MIN, Y_MAX);

    generate
        for (genvar gi = 0; gi < N_ENEMY; gi++) begin : g_hit
            player_hit_detect u_hit (
                .pos_x       (pos_x_reg),
                .pos_y       (pos_y_reg),
                .enemy_x     (enemy_x[10*gi +: 10]),
                .enemy_y     (enemy_y[10*gi +: 10]),
                .enemy_size  (enemy_size[10*gi +: 10]),
                .enemy_alive (enemy_alive[gi]),
                .overlap     (overlap_vec[gi])
            );
        end
    endgenerate

`ifdef PLAYER_INVULN_EN
    localparam int CW = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;
    logic [CW-1:0] frame_cnt_reg;
    logic          invuln_reg;
`endif

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_reg     <= ST_ALIVE;
            pos_x_reg     <= SPAWN_X;
            pos_y_reg     <= SPAWN_Y;
            lives_reg     <= 3'(LIVES);
            hit_vec_reg   <= '0;
            game_over_reg <= 1'b0;
`ifdef PLAYER_INVULN_EN
            invuln_reg    <= 1'b0;
            frame_cnt_reg <= '0;
`endif
        end else begin
            case (state_reg)
                ST_ALIVE: begin
                    pos_x_reg <= x_next;
                    pos_y_reg <= y_next;
                    if (|overlap_vec) begin
                        state_reg   <= ST_HIT;
                        hit_vec_reg <= overlap_vec;
                        lives_reg   <= lives_reg - 3'd1;
                    end
                end
                ST_HIT: begin
                    pos_x_reg <= SPAWN_X;
                    pos_y_reg <= SPAWN_Y;
                    if (lives_reg == 3'd0) begin
                        state_reg     <= ST_DEAD;
                        game_over_reg <= 1'b1;
                    end else begin
`ifdef PLAYER_INVULN_EN
                        state_reg     <= ST_INVULN;
                        invuln_reg    <= 1'b1;
                        frame_cnt_reg <= '0;
`else
                        state_reg     <= ST_ALIVE;
`endif
                    end
                end
                ST_INVULN: begin
`ifdef PLAYER_INVULN_EN
                    pos_x_reg <= x_next;
                    pos_y_reg <= y_next;
                    if (frame_cnt_reg == CW'(INVULN_FRAMES - 1)) begin
                        state_reg  <= ST_ALIVE;
                        invuln_reg <= 1'b0;
                    end else begin
                        frame_cnt_reg <= frame_cnt_reg + 1'b1;
                    end
`else
                    state_reg <= ST_ALIVE;
`endif
                end
                ST_DEAD: begin
                    if (start) begin
                        lives_reg     <= 3'(LIVES);
                        hit_vec_reg   <= '0;
                        game_over_reg <= 1'b0;
`ifdef PLAYER_INVULN_EN
                        state_reg     <= ST_INVULN;
                        invuln_reg    <= 1'b1;
                        frame_cnt_reg <= '0;
`else
                        state_reg     <= ST_ALIVE;
`endif
                    end
                end
                default: state_reg <= ST_ALIVE;
            endcase
        end
    end

    assign pos_x     = pos_x_reg;
    assign pos_y     = pos_y_reg;
    assign half_w    = 10'(HALF_W);
    assign half_h    = 10'(HALF_H);
    assign lives     = lives_reg;
    assign hit_vec   = hit_vec_reg;
    assign game_over = game_over_reg;
`ifdef PLAYER_INVULN_EN
    assign invuln    = invuln_reg;
`else
    assign invuln    = 1'b0;
`endif

endmodule

// File: tb/tb_player_sprite_ctrl.sv
// Scoreboard bench for player_sprite_ctrl: directed scenarios then random frames,
// compared against a frame-level behavioural model of the game rules.
module tb_player_sprite_ctrl;

    localparam int NE    = 4;
    localparam int NK    = 3;
    localparam int STEP  = 3;
    localparam int LIVES = 3;
    localparam int INV   = 120;
`ifdef PLAYER_INVULN_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic              frame_clk;
    logic              Reset;
    logic [8*NK-1:0]   keycode;
    logic [10*NE-1:0]  enemy_x;
    logic [10*NE-1:0]  enemy_y;
    logic [10*NE-1:0]  enemy_size;
    logic [NE-1:0]     enemy_alive;
    logic              start;
    logic [9:0]        pos_x, pos_y, half_w, half_h;
    logic [2:0]        lives;
    logic [NE-1:0]     hit_vec;
    logic              invuln, game_over;

    player_sprite_ctrl #(
        .N_ENEMY(NE), .N_KEYS(NK), .STEP(STEP), .LIVES(LIVES), .INVULN_FRAMES(INV)
    ) dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .enemy_x     (enemy_x),
        .enemy_y     (enemy_y),
        .enemy_size  (enemy_size),
        .enemy_alive (enemy_alive),
        .start       (start),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .half_w      (half_w),
        .half_h      (half_h),
        .lives       (lives),
        .hit_vec     (hit_vec),
        .invuln      (invuln),
        .game_over   (game_over)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int px;
        int py;
        int lv;
        int hv;
        int inv;
        int go;
    } exp_t;

    exp_t q[$];
    event mon_ev;
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Model state: game phase is captured as flags and a remaining-frames count.
    int m_px, m_py, m_lv, m_hv, m_inv_left;
    bit m_hit_pend, m_dead;
    int ex[NE], ey[NE], es[NE];
    bit ea[NE];

    function automatic int clampi(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.px  = m_px;
        e.py  = m_py;
        e.lv  = m_lv;
        e.hv  = m_hv;
        e.inv = (m_inv_left > 0) ? 1 : 0;
        e.go  = m_dead ? 1 : 0;
        return e;
    endfunction

    task automatic model_reset();
        m_px = 320; m_py = 450; m_lv = LIVES; m_hv = 0;
        m_inv_left = 0; m_hit_pend = 0; m_dead = 0;
    endtask

    task automatic model_frame(input logic [8*NK-1:0] kc, input bit st);
        bit a, d, w, s;
        int ov, dxv, dyv;
        logic [7:0] kb;
        a = 0; d = 0; w = 0; s = 0;
        for (int k = 0; k < NK; k++) begin
            kb = kc[8*k +: 8];
            if (kb == 8'h04) a = 1;
            if (kb == 8'h07) d = 1;
            if (kb == 8'h1A) w = 1;
            if (kb == 8'h16) s = 1;
        end
        if (m_hit_pend) begin
            m_px = 320; m_py = 450; m_hit_pend = 0;
            if (m_lv == 0) m_dead = 1;
            else if (INV_EN) m_inv_left = INV;
        end else if (m_dead) begin
            if (st) begin
                m_lv = LIVES; m_hv = 0; m_dead = 0;
                if (INV_EN) m_inv_left = INV;
            end
        end else begin
            ov = 0;
            for (int i = 0; i < NE; i++)
                if (ea[i] && (m_px - 17 <= ex[i] + es[i]) && (m_px + 17 > ex[i]) &&
                    (m_py - 16 <= ey[i] + es[i]) && (m_py + 16 > ey[i]))
                    ov |= (1 << i);
            dxv = (d ? STEP : 0) - (a ? STEP : 0);
            dyv = (s ? STEP : 0) - (w ? STEP : 0);
            m_px = clampi(m_px + dxv, 6 + 17, 633 - 17);
            m_py = clampi(m_py + dyv, 6 + 16, 473 - 16);
            if (m_inv_left > 0) m_inv_left--;
            else if (ov != 0) begin
                m_hit_pend = 1; m_hv = ov; m_lv--;
            end
        end
    endtask

    // Called at a falling edge: drive one frame of inputs and queue its result.
    task automatic frame(input logic [8*NK-1:0] kc, input bit st);
        keycode = kc;
        start   = st;
        for (int i = 0; i < NE; i++) begin
            enemy_x[10*i +: 10]    = 10'(ex[i]);
            enemy_y[10*i +: 10]    = 10'(ey[i]);
            enemy_size[10*i +: 10] = 10'(es[i]);
            enemy_alive[i]         = ea[i];
        end
        model_frame(kc, st);
        q.push_back(snapshot());
        @(negedge frame_clk);
    endtask

    task automatic pulse_reset();
        #1 Reset = 1'b1;
        model_reset();
        q.push_back(snapshot());
        -> mon_ev;
        #2 Reset = 1'b0;
    endtask

    task automatic set_enemy(input int i, input int x, input int y, input int sz, input bit al);
        ex[i] = x; ey[i] = y; es[i] = sz; ea[i] = al;
    endtask

    function automatic logic [7:0] pick_key();
        case ($urandom_range(0, 6))
            0: return 8'h04;
            1: return 8'h07;
            2: return 8'h1A;
            3: return 8'h16;
            4: return 8'(8'h20 + $urandom_range(0, 15));
            default: return 8'h00;
        endcase
    endfunction

    // Monitor: compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge frame_clk or mon_ev);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                txn++;
                if (pos_x !== 10'(e.px) || pos_y !== 10'(e.py) || lives !== 3'(e.lv) ||
                    hit_vec !== NE'(e.hv) || invuln !== 1'(e.inv) || game_over !== 1'(e.go) ||
                    half_w !== 10'd17 || half_h !== 10'd16) begin
                    errors++;
                    $display("FAIL txn%0d outputs: got pos=(%0d,%0d) lives=%0d hit=%b inv=%b go=%b half=(%0d,%0d) want pos=(%0d,%0d) lives=%0d hit=%b inv=%0d go=%0d half=(17,16)",
                             txn, pos_x, pos_y, lives, hit_vec, invuln, game_over, half_w, half_h,
                             e.px, e.py, e.lv, 4'(e.hv), e.inv, e.go);
                end else begin
                    $display("txn%0d ok pos=(%0d,%0d) lives=%0d hit=%b inv=%b go=%b",
                             txn, pos_x, pos_y, lives, hit_vec, invuln, game_over);
                end
            end
        end
    end

    initial begin
        logic [8*NK-1:0] kc;
        Reset = 1'b1;
        keycode = '0; start = 1'b0;
        enemy_x = '0; enemy_y = '0; enemy_size = '0; enemy_alive = '0;
        for (int i = 0; i < NE; i++) set_enemy(i, 0, 0, 0, 0);
        model_reset();
        @(negedge frame_clk);
        pulse_reset();

        repeat (10) frame(24'h00_07_00, 0);       // D in slot 1 -> x 350
        repeat (5)  frame(24'h07_00_04, 0);       // A and D cancel
        repeat (115) frame(24'h00_00_04, 0);      // A until clamped at left edge
        repeat (3)  frame(24'h00_1A_07, 0);       // diagonal up-right
        repeat (3)  frame(24'h00_00_04, 0);

        // Two overlapping enemies in one frame: one life lost, both flagged.
        set_enemy(0, 20, 440, 10, 1);
        set_enemy(1, 500, 100, 10, 1);
        set_enemy(2, 0, 430, 30, 1);
        set_enemy(3, 15, 445, 20, 0);
        frame(24'h0, 0);
        for (int i = 0; i < NE; i++) ea[i] = 0;
        frame(24'h0, 0);

        // Persistent enemy at spawn: invulnerability then repeated hits to death.
        set_enemy(1, 310, 440, 20, 1);
        repeat (400) frame(24'h0, 0);
        ea[1] = 0;
        repeat (3) frame(24'h0, 0);
        frame(24'h0, 1);                          // restart from DEAD
        repeat (10) frame(24'h00_16_00, 0);
        pulse_reset();                            // mid-INVULN when enabled
        repeat (3) frame(24'h0, 0);

        // Randomized play.
        for (int n = 0; n < 1500; n++) begin
            if (n % 16 == 0)
                for (int i = 0; i < NE; i++)
                    set_enemy(i, clampi(m_px - 50 + int'($urandom_range(0, 80)), 0, 1023),
                                 clampi(m_py - 50 + int'($urandom_range(0, 80)), 0, 1023),
                                 int'($urandom_range(0, 40)), ($urandom_range(0, 3) == 0));
            for (int k = 0; k < NK; k++) kc[8*k +: 8] = pick_key();
            if ($urandom_range(0, 399) == 0) pulse_reset();
            frame(kc, ($urandom_range(0, 19) == 0));
        end

        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_sprite_ctrl.md
PLAYER_SPRITE_CTRL -- requirements
Module: player_sprite_ctrl

Interface
REQ-001 SHALL have parameter N_ENEMY, default 4: number of enemy channels checked for collision.
REQ-002 SHALL have parameter N_KEYS, default 3: number of 8-bit keycode slots.
REQ-003 SHALL have parameter STEP, default 3: pixels moved per frame per axis.
REQ-004 SHALL have parameter LIVES, default 3: lives at reset and restart, 1..7.
REQ-005 SHALL have parameter INVULN_FRAMES, default 120: invulnerable frames after respawn.
REQ-006 SHALL have port frame_clk, input, 1: the only clock, one rising edge per frame.
REQ-007 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port keycode, input, 8*N_KEYS: USB keycode slots; slot k is bits [8k+7:8k].
REQ-009 SHALL have ports enemy_x, enemy_y, enemy_size, input, 10 each x N_ENEMY: enemy top-left corner and edge length.
REQ-010 SHALL have port enemy_alive, input, N_ENEMY: per-enemy collision enable.
REQ-011 SHALL have port start, input, 1: restart request, sampled only in DEAD.
REQ-012 SHALL have ports pos_x, pos_y, output, 10: player centre.
REQ-013 SHALL have ports half_w, half_h, output, 10: constants 17 and 16.
REQ-014 SHALL have port lives, output, 3: remaining lives.
REQ-015 SHALL have port hit_vec, output, N_ENEMY: enemies struck on the last collision.
REQ-016 SHALL have ports invuln, game_over, output, 1: state flags.

Function
REQ-017 SHALL run the FSM ALIVE, HIT, INVULN, DEAD, advancing at most one state per frame.
REQ-018 SHALL decode keys from any slot: A=0x04, D=0x07, W=0x1A, S=0x16; opposing keys held together SHALL cancel to zero motion on that axis.
REQ-019 SHALL move only in ALIVE and INVULN, both axes in the same frame when both are pressed (diagonal movement).
REQ-020 SHALL compute next position in 11-bit signed arithmetic and clamp the centre to X[6+17, 633-17] and Y[6+16, 473-16]; it SHALL never wrap.
REQ-021 SHALL flag enemy i as overlapping when enemy_alive[i] && pos_x-17 <= ex+size && pos_x+17 > ex && pos_y-16 <= ey+size && pos_y+16 > ey, using the registered position.
REQ-022 SHALL, in ALIVE, on any overlap, go to HIT next frame, latch hit_vec, and decrement lives by exactly one, however many enemies overlap.
REQ-023 SHALL, in HIT (one frame), load spawn position (320,450), then go to DEAD if lives==0, else to INVULN.
REQ-024 SHALL, in INVULN, ignore overlaps, assert invuln, count INVULN_FRAMES frames, then return to ALIVE.
REQ-025 SHALL, in DEAD, assert game_over, hold position, and on start=1 restore lives=LIVES, clear hit_vec, and enter INVULN.
REQ-026 SHALL ignore start outside DEAD.

Reset
REQ-027 SHALL, on Reset, asynchronously set pos=(320,450), lives=LIVES, state ALIVE, hit_vec=0, invuln=0, game_over=0, and the frame counter to 0.
REQ-028 SHALL let Reset asserted in any state, including mid-INVULN, override all pending transitions.

Configuration
REQ-029 SHALL, when PLAYER_INVULN_EN is defined, implement INVULN as specified.
REQ-030 SHALL, without PLAYER_INVULN_EN, go from HIT directly to ALIVE (or to DEAD), go from a DEAD restart directly to ALIVE, tie invuln to 0, and omit the counter.

Structure
REQ-031 SHALL place the state enum, key constants, screen bounds, spawn point and half sizes in package player_pkg.
REQ-032 SHALL put the per-enemy overlap test in combinational sub-module player_hit_detect, instantiated N_ENEMY times.

Verification
REQ-033 SHALL verify: reset, then keycode slot1=0x07 held 10 frames -> pos_x=350, pos_y=450.
REQ-034 SHALL verify: A and D both held -> pos_x unchanged; A held from x=30 -> clamps at 23 with no wrap.
REQ-035 SHALL verify: enemies 0 and 2 overlap in one frame -> hit_vec=0101, lives 3->2, pos=(320,450) after HIT.
REQ-036 SHALL verify: with PLAYER_INVULN_EN, an overlap during INVULN -> lives unchanged; invuln deasserts after exactly 120 frames.
REQ-037 SHALL verify: third hit -> lives=0, game_over=1; start=1 -> lives=3, game_over=0.
REQ-038 SHALL verify: Reset pulsed mid-INVULN -> all outputs at reset values immediately.
